// File: rtl/load_store_unit_if.sv
// Issue, broadcast and RAM signals of the byte-serial load/store unit.
// The master side is the issuer plus RAM; the slave side is the LSU.
interface load_store_unit_if;
  logic [4:0]  memory_op;
  logic [31:0] memory_value1;
  logic [31:0] memory_value2;
  logic [31:0] memory_imm;
  logic [2:0]  memory_des;
  logic        lsu_busy;
  logic [31:0] result_data;
  logic [2:0]  result_des;
  logic        result_fault;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;

  modport master (
    output memory_op, memory_value1, memory_value2, memory_imm, memory_des, mem_din,
    input  lsu_busy, result_data, result_des, result_fault, mem_a, mem_dout, mem_wr
  );

  modport slave (
    input  memory_op, memory_value1, memory_value2, memory_imm, memory_des, mem_din,
    output lsu_busy, result_data, result_des, result_fault, mem_a, mem_dout, mem_wr
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte-serial load/store unit: one op at a time, one RAM byte per cycle, result on the CDB.
// Optional misalignment trap enabled by defining LSU_ALIGN_CHECK_EN.
module load_store_unit (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DRAIN, S_RESULT} state_t;

  localparam logic [4:0] OP_LB  = 5'b10010;
  localparam logic [4:0] OP_LH  = 5'b10011;
  localparam logic [4:0] OP_LW  = 5'b10100;
  localparam logic [4:0] OP_LBU = 5'b10101;
  localparam logic [4:0] OP_LHU = 5'b10110;
  localparam logic [4:0] OP_SB  = 5'b10111;
  localparam logic [4:0] OP_SH  = 5'b11000;
  localparam logic [4:0] OP_SW  = 5'b11001;

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [1:0]  prev_k, last_k;
  logic [31:0] addr_q, addr_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] store_q, store_d;
  logic [2:0]  tag_q, tag_d;
  logic [31:0] load_q, load_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        busy_q, busy_d;
  logic [31:0] result_data_q, result_data_d;
  logic [2:0]  result_des_q, result_des_d;

  function automatic logic is_valid(input logic [4:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic is_store(input logic [4:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic [1:0] last_idx(input logic [4:0] op);
    case (op)
      OP_LH, OP_LHU, OP_SH: return 2'd1;
      OP_LW, OP_SW:         return 2'd3;
      default:              return 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [4:0] op, input logic [31:0] w);
    case (op)
      OP_LB:   return {{24{w[7]}}, w[7:0]};
      OP_LH:   return {{16{w[15]}}, w[15:0]};
      OP_LBU:  return {24'h0, w[7:0]};
      OP_LHU:  return {16'h0, w[15:0]};
      OP_LW:   return w;
      default: return 32'h0;
    endcase
  endfunction

`ifdef LSU_ALIGN_CHECK_EN
  logic fault_q, fault_d;

  function automatic logic misaligned(input logic [4:0] op, input logic [31:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH: return a[0];
      OP_LW, OP_SW:         return |a[1:0];
      default:              return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end

  assign bus.result_fault = fault_q;
`else
  assign bus.result_fault = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    addr_d        = addr_q;
    op_d          = op_q;
    store_d       = store_q;
    tag_d         = tag_q;
    load_d        = load_q;
    result_des_d  = 3'd0;
    result_data_d = 32'h0;
    prev_k        = k_q - 2'd1;
    last_k        = last_idx(op_q);
`ifdef LSU_ALIGN_CHECK_EN
    fault_d       = 1'b0;
`endif

    case (state_q)
      // RESULT accepts like IDLE so ops can run back-to-back.
      S_IDLE, S_RESULT: begin
        state_d = S_IDLE;
        if (is_valid(bus.memory_op)) begin
          op_d    = bus.memory_op;
          addr_d  = bus.memory_value1 + bus.memory_imm;
          store_d = bus.memory_value2;
          tag_d   = bus.memory_des;
          k_d     = 2'd0;
          load_d  = 32'h0;
          state_d = S_ACCESS;
`ifdef LSU_ALIGN_CHECK_EN
          if (misaligned(op_d, addr_d)) begin
            state_d      = S_RESULT;
            result_des_d = bus.memory_des;
            fault_d      = 1'b1;
          end
`endif
        end
      end
      S_ACCESS: begin
        // mem_din lags the address by one cycle, so it carries byte k-1.
        if (!is_store(op_q) && k_q != 2'd0)
          load_d[{prev_k, 3'b000} +: 8] = bus.mem_din;
        if (k_q == last_k) begin
          if (is_store(op_q)) begin
            state_d      = S_RESULT;
            result_des_d = tag_q;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      S_DRAIN: begin
        load_d[{last_k, 3'b000} +: 8] = bus.mem_din;
        state_d       = S_RESULT;
        result_des_d  = tag_q;
        result_data_d = extend(op_q, load_d);
      end
      default: state_d = S_IDLE;
    endcase

    mem_a_d    = (state_d == S_ACCESS) ? addr_d + {30'h0, k_d} : 32'h0;
    mem_wr_d   = (state_d == S_ACCESS) && is_store(op_d);
    mem_dout_d = mem_wr_d ? store_d[{k_d, 3'b000} +: 8] : 8'h00;
    busy_d     = (state_d == S_ACCESS) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      k_q           <= 2'd0;
      addr_q        <= 32'h0;
      op_q          <= 5'b11111;
      store_q       <= 32'h0;
      tag_q         <= 3'd0;
      load_q        <= 32'h0;
      mem_a_q       <= 32'h0;
      mem_dout_q    <= 8'h00;
      mem_wr_q      <= 1'b0;
      busy_q        <= 1'b0;
      result_data_q <= 32'h0;
      result_des_q  <= 3'd0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      addr_q        <= addr_d;
      op_q          <= op_d;
      store_q       <= store_d;
      tag_q         <= tag_d;
      load_q        <= load_d;
      mem_a_q       <= mem_a_d;
      mem_dout_q    <= mem_dout_d;
      mem_wr_q      <= mem_wr_d;
      busy_q        <= busy_d;
      result_data_q <= result_data_d;
      result_des_q  <= result_des_d;
    end
  end

  assign bus.mem_a       = mem_a_q;
  assign bus.mem_dout    = mem_dout_q;
  assign bus.mem_wr      = mem_wr_q;
  assign bus.lsu_busy    = busy_q;
  assign bus.result_data = result_data_q;
  assign bus.result_des  = result_des_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected broadcasts and RAM writes are queued
// at issue time and matched by a negedge monitor, including the cycle they appear in.
module tb_load_store_unit;
  localparam logic [4:0] OP_LB  = 5'b10010;
  localparam logic [4:0] OP_LH  = 5'b10011;
  localparam logic [4:0] OP_LW  = 5'b10100;
  localparam logic [4:0] OP_LBU = 5'b10101;
  localparam logic [4:0] OP_LHU = 5'b10110;
  localparam logic [4:0] OP_SB  = 5'b10111;
  localparam logic [4:0] OP_SH  = 5'b11000;
  localparam logic [4:0] OP_SW  = 5'b11001;

  typedef struct {
    logic [2:0]  tag;
    logic [31:0] data;
    logic        fault;
    int          cyc;
  } bc_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;
  bc_t  bq[$];
  wr_t  wq[$];
  logic [7:0] ram [0:4095];

  load_store_unit_if bus();

  load_store_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte RAM with one-cycle read latency; only the low 12 address bits decode.
  always @(posedge clk) begin
    if (bus.mem_wr) ram[bus.mem_a[11:0]] <= bus.mem_dout;
    bus.mem_din <= ram[bus.mem_a[11:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_bc(input logic [2:0] tag, input logic [31:0] data, input logic fault, input int lat);
    bc_t e;
    e.tag = tag; e.data = data; e.fault = fault; e.cyc = cyc + lat;
    bq.push_back(e);
  endtask

  task automatic exp_wr(input logic [31:0] addr, input logic [7:0] data, input int k);
    wr_t e;
    e.addr = addr; e.data = data; e.cyc = cyc + 1 + k;
    wq.push_back(e);
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] imm, input logic [2:0] des);
    bus.memory_op     = op;
    bus.memory_value1 = v1;
    bus.memory_value2 = v2;
    bus.memory_imm    = imm;
    bus.memory_des    = des;
    step();
    bus.memory_op     = 5'b11111;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.lsu_busy && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check("wait_idle_timeout", 32'(bus.lsu_busy), 32'd0);
  endtask

  // Monitor: every broadcast and every RAM write must match the head of its queue.
  always @(negedge clk) begin
    bc_t b;
    wr_t w;
    if (bus.result_des != 3'd0) begin
      if (bq.size() == 0) begin
        check("unexpected_bcast_tag", 32'(bus.result_des), 32'd0);
      end else begin
        b = bq.pop_front();
        $display("bcast tag=%0d data=0x%08h fault=%0d cycle=%0d", bus.result_des,
                 bus.result_data, bus.result_fault, cyc);
        check("bcast_tag", 32'(bus.result_des), 32'(b.tag));
        check("bcast_data", bus.result_data, b.data);
        check("bcast_fault", 32'(bus.result_fault), 32'(b.fault));
        check("bcast_cycle", 32'(cyc), 32'(b.cyc));
        check("busy_in_result", 32'(bus.lsu_busy), 32'd0);
      end
    end else if (bus.result_fault) begin
      check("fault_without_tag", 32'(bus.result_fault), 32'd0);
    end
    if (bus.mem_wr) begin
      if (wq.size() == 0) begin
        check("unexpected_write", 32'(bus.mem_wr), 32'd0);
      end else begin
        w = wq.pop_front();
        $display("write addr=0x%08h data=0x%02h cycle=%0d", bus.mem_a, bus.mem_dout, cyc);
        check("write_addr", bus.mem_a, w.addr);
        check("write_data", 32'(bus.mem_dout), 32'(w.data));
        check("write_cycle", 32'(cyc), 32'(w.cyc));
      end
    end
  end

  initial begin
    cyc = 0;
    checks = 0;
    failures = 0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    rst = 1'b1;
    bus.memory_op = 5'b11111;
    bus.memory_value1 = 32'h0;
    bus.memory_value2 = 32'h0;
    bus.memory_imm = 32'h0;
    bus.memory_des = 3'd0;
    repeat (3) step();

    check("rst_busy", 32'(bus.lsu_busy), 32'd0);
    check("rst_result_des", 32'(bus.result_des), 32'd0);
    check("rst_result_data", bus.result_data, 32'h0);
    check("rst_result_fault", 32'(bus.result_fault), 32'd0);
    check("rst_mem_a", bus.mem_a, 32'h0);
    check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    check("rst_mem_dout", 32'(bus.mem_dout), 32'd0);
    rst = 1'b0;
    step();

    // SW 0xA1B2C3D4 to 0x104..0x107
    exp_wr(32'h104, 8'hD4, 0);
    exp_wr(32'h105, 8'hC3, 1);
    exp_wr(32'h106, 8'hB2, 2);
    exp_wr(32'h107, 8'hA1, 3);
    exp_bc(3'd3, 32'h0, 1'b0, 5);
    issue(OP_SW, 32'h100, 32'hA1B2C3D4, 32'd4, 3'd3);
    wait_idle();

    exp_bc(3'd5, 32'hFFFFFFA1, 1'b0, 3);
    issue(OP_LB, 32'h100, 32'h0, 32'd7, 3'd5);
    wait_idle();
    exp_bc(3'd2, 32'h000000A1, 1'b0, 3);
    issue(OP_LBU, 32'h100, 32'h0, 32'd7, 3'd2);
    wait_idle();
    exp_bc(3'd4, 32'hFFFFA1B2, 1'b0, 4);
    issue(OP_LH, 32'h100, 32'h0, 32'd6, 3'd4);
    wait_idle();
    exp_bc(3'd6, 32'hA1B2C3D4, 1'b0, 6);
    issue(OP_LW, 32'h100, 32'h0, 32'd4, 3'd6);
    wait_idle();
    exp_bc(3'd7, 32'h0000C3D4, 1'b0, 4);
    issue(OP_LHU, 32'h108, 32'h0, 32'hFFFFFFFC, 3'd7);
    wait_idle();

    // SB presented in the LHU's RESULT cycle
    exp_wr(32'h201, 8'h80, 0);
    exp_bc(3'd1, 32'h0, 1'b0, 2);
    issue(OP_SB, 32'h200, 32'hFFFFFF80, 32'd1, 3'd1);
    wait_idle();
    exp_bc(3'd2, 32'hFFFFFF80, 1'b0, 3);
    issue(OP_LB, 32'h200, 32'h0, 32'd1, 3'd2);
    wait_idle();

    // Tag 0 store: write happens, broadcast invisible
    exp_wr(32'h210, 8'h77, 0);
    issue(OP_SB, 32'h210, 32'h00000077, 32'd0, 3'd0);
    wait_idle();
    exp_bc(3'd5, 32'h00000077, 1'b0, 3);
    issue(OP_LBU, 32'h200, 32'h0, 32'h10, 3'd5);
    wait_idle();

    // Unlisted op code is ignored
    issue(5'b00000, 32'h100, 32'h0, 32'd0, 3'd7);
    check("bad_op_busy", 32'(bus.lsu_busy), 32'd0);
    check("bad_op_mem_a", bus.mem_a, 32'h0);
    step();

`ifdef LSU_ALIGN_CHECK_EN
    exp_bc(3'd2, 32'h0, 1'b1, 1);
    issue(OP_SH, 32'hFFFFFFFE, 32'h00001234, 32'd1, 3'd2);
    check("wrap_fault_mem_wr", 32'(bus.mem_wr), 32'd0);
    check("wrap_fault_busy", 32'(bus.lsu_busy), 32'd0);
    wait_idle();

    exp_bc(3'd7, 32'h0, 1'b1, 1);
    issue(OP_LW, 32'h100, 32'h0, 32'd2, 3'd7);
    check("misaligned_lw_busy", 32'(bus.lsu_busy), 32'd0);
    check("misaligned_lw_mem_a", bus.mem_a, 32'h0);
    wait_idle();
`else
    exp_wr(32'hFFFFFFFF, 8'h34, 0);
    exp_wr(32'h00000000, 8'h12, 1);
    exp_bc(3'd2, 32'h0, 1'b0, 3);
    issue(OP_SH, 32'hFFFFFFFE, 32'h00001234, 32'd1, 3'd2);
    check("wrap_addr0", bus.mem_a, 32'hFFFFFFFF);
    step();
    check("wrap_addr1", bus.mem_a, 32'h00000000);
    wait_idle();
    exp_bc(3'd3, 32'h00001234, 1'b0, 4);
    issue(OP_LHU, 32'hFFFFFFFF, 32'h0, 32'd0, 3'd3);
    wait_idle();

    exp_bc(3'd7, 32'hC3D40000, 1'b0, 6);
    issue(OP_LW, 32'h100, 32'h0, 32'd2, 3'd7);
    for (int i = 0; i < 4; i++) begin
      check("misaligned_lw_addr", bus.mem_a, 32'h102 + 32'(i));
      if (i < 3) step();
    end
    wait_idle();
`endif

    // Reset during the second byte of an SW
    exp_wr(32'h300, 8'h44, 0);
    exp_wr(32'h301, 8'h33, 1);
    issue(OP_SW, 32'h300, 32'h11223344, 32'd0, 3'd4);
    step();
    rst = 1'b1;
    step();
    check("abort_mem_wr", 32'(bus.mem_wr), 32'd0);
    check("abort_busy", 32'(bus.lsu_busy), 32'd0);
    rst = 1'b0;
    repeat (8) step();

    exp_bc(3'd3, 32'h00000033, 1'b0, 3);
    issue(OP_LBU, 32'h301, 32'h0, 32'd0, 3'd3);
    wait_idle();
    exp_bc(3'd4, 32'h00000000, 1'b0, 3);
    issue(OP_LBU, 32'h302, 32'h0, 32'd0, 3'd4);
    wait_idle();

    repeat (5) step();
    check("bcast_queue_drained", 32'(bq.size()), 32'd0);
    check("write_queue_drained", 32'(wq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Byte-serial load/store execution unit sitting between the reservation station's memory issue port and the 8-bit unified RAM. Accepts one memory op (op, base, store data, immediate, destination tag), computes the effective address, and performs the access one byte per cycle. It broadcasts the result on the common data bus as a one-cycle (tag, data) pair, the same pair the reservation station snoops as `memory_des_in`/`memory_data`. Tag 0 means "no broadcast".

## Interface
- No parameters.
- `clk` input 1: system clock, all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `memory_op` input 5: op code. 5'b11111 means no request. Accepted codes: LB 10010, LH 10011, LW 10100, LBU 10101, LHU 10110, SB 10111, SH 11000, SW 11001. Any other code is treated as no request.
- `memory_value1` input 32: base register value.
- `memory_value2` input 32: store data; ignored for loads.
- `memory_imm` input 32: sign-extended offset.
- `memory_des` input 3: destination tag, 1..7.
- `lsu_busy` output 1: high while an op is in flight; the issuer must not present a request while it is high.
- `result_data` output 32: broadcast data.
- `result_des` output 3: broadcast tag; nonzero for exactly one cycle per op.
- `result_fault` output 1: misalignment flag (see Configuration).
- `mem_a` output 32: RAM byte address.
- `mem_dout` output 8: RAM write byte.
- `mem_wr` output 1: RAM write enable.
- `mem_din` input 8: RAM read byte. Valid the cycle after its address is driven.

## Operation
- States:
  - IDLE.
  - ACCESS: counter k = 0..N-1, where N = 1/2/4 for B/H/W.
  - DRAIN: loads only; captures the last byte.
  - RESULT.
- IDLE: a request with a valid code at a rising edge is accepted.
  - Latch addr = value1 + imm, modulo 2^32. Carry is dropped; wrap to 0x0000_0000 is legal.
  - Latch op, store data and tag. Go to ACCESS, k=0.
- ACCESS:
  - Drive `mem_a` = addr + k, modulo 2^32.
  - Stores drive `mem_wr`=1 and `mem_dout` = store byte k, little-endian (byte 0 = bits 7:0).
  - Loads capture `mem_din` into byte k-1 when k>0.
  - After k = N-1: stores go to RESULT, loads go to DRAIN.
- DRAIN: capture byte N-1, `mem_wr`=0, go to RESULT.
- RESULT: drive `result_des` = tag and `result_data`, then go to IDLE.
  - LB/LH: sign-extend. LBU/LHU: zero-extend. LW: raw word. Stores: data 0.
- Outside ACCESS: `mem_a`=0, `mem_wr`=0, `mem_dout`=0.
- `lsu_busy` is high in ACCESS and DRAIN, low in IDLE and RESULT.
- A request presented during RESULT is accepted at the edge ending RESULT (back-to-back).
- Requests arriving while busy are dropped. Dropping them is a protocol violation by the issuer, not an error in this block.
- Tag 0 on an accepted request: the access is still performed, and the broadcast carries tag 0, i.e. it is invisible.

## Timing
- Reset values: state IDLE, `lsu_busy`=0, `result_des`=0, `result_data`=0, `result_fault`=0, `mem_a`=0, `mem_dout`=0, `mem_wr`=0.
- Reset mid-operation aborts the op: no further write bytes and no broadcast. A partially written store remains in RAM.
- All outputs are registered. Accept edge = E0.
- Cycle after edge Ek (k < N) presents byte k.
- Store broadcast is visible after edge EN. Load broadcast is visible after edge E(N+1).
- Latencies, accept to broadcast cycle: SB 2, SH 3, SW 5, LB 3, LH 4, LW 6.
- Maximum throughput is one op per N+1 (store) or N+2 (load) cycles.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, skips ACCESS and DRAIN.
  - RESULT follows in the cycle after E0, with `result_fault`=1, `result_data`=0 and the tag.
  - No RAM access occurs (`mem_wr` stays 0).
  - `result_fault` is 0 in all other cycles.
- `LSU_ALIGN_CHECK_EN` undefined: misaligned accesses proceed byte-serially as normal; `result_fault` is tied 0.

## Test plan
- SW, value1=0x100, imm=4, value2=0xA1B2C3D4, tag 3:
  - writes 0xD4,0xC3,0xB2,0xA1 to 0x104..0x107 on 4 consecutive cycles;
  - then `result_des`=3, data 0, one cycle.
- After that store, LB at 0x107 tag 5 → 0xFFFFFFA1. LBU at 0x107 → 0x000000A1. LH at 0x106 → 0xFFFFA1B2. LW at 0x104 → 0xA1B2C3D4, broadcast 6 cycles after accept.
- Back-to-back: SB tag 1 presented during the previous RESULT → accepted at that edge; `lsu_busy` never high during any RESULT cycle.
- Wrap: value1=0xFFFFFFFE, imm=1, SH → `mem_a` 0xFFFFFFFF then 0x00000000.
- `rst` asserted in cycle 2 of an SW:
  - the next cycle shows `mem_wr`=0 and `lsu_busy`=0;
  - no nonzero `result_des` afterwards.
- Misaligned LW at 0x102:
  - with `LSU_ALIGN_CHECK_EN` → fault broadcast in the cycle after accept, no RAM access;
  - without it → 4 byte reads at 0x102..0x105.
